// File: rtl/cmos_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : cmos_capture_if
// Brief    : Sensor DVP inputs and vip-facing pixel outputs of cmos_capture.
// Revision : 1.0 - initial release
// ============================================================================
interface cmos_capture_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        cam_vs;
  logic        cam_de;
  logic [15:0] cam_data;
  logic        data_en;
  logic        frame_err;

  // master drives the sensor bus, slave is the capture block
  modport master (
    output cmos_vsync, cmos_href, cmos_data,
    input  cam_vs, cam_de, cam_data, data_en, frame_err
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data,
    output cam_vs, cam_de, cam_data, data_en, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/cmos_capture.sv
`default_nettype none
// ============================================================================
// Module   : cmos_capture
// Brief    : DVP byte-pair to RGB565 assembly, post-reset frame skip and
//            per-frame geometry checking.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIX      = 1280,
  parameter int V_LINES    = 960
) (
  input wire            clk,
  input wire            rst,
  cmos_capture_if.slave bus
);
  localparam logic [7:0]  SKIP_LIM  = 8'(FRAME_SKIP);
  localparam logic [10:0] H_PIX_LIM = 11'(H_PIX);
  localparam logic [9:0]  V_LIN_LIM = 10'(V_LINES);

  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic        href_s1_q, href_s1_d, href_s2_q, href_s2_d;
  logic [7:0]  byte_s1_q, byte_s1_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] pix_q, pix_d;
  logic        pix_vld_q, pix_vld_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic        line_bad_q, line_bad_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        seen_q, seen_d;
  logic        frame_err_q, frame_err_d;
  logic        cam_vs_q, cam_vs_d;
  logic        cam_de_q, cam_de_d;
  logic        data_en_q, data_en_d;
  logic [15:0] cam_data_q, cam_data_d;

  logic frame_start, href_fall, pix_stb;

  always_comb begin
    frame_start = vs_s1_q & ~vs_s2_q;
    href_fall   = href_s2_q & ~href_s1_q;
    pix_stb     = href_s1_q & phase_q;

    vs_s1_d   = bus.cmos_vsync;
    href_s1_d = bus.cmos_href;
    byte_s1_d = bus.cmos_data;
    vs_s2_d   = vs_s1_q;
    href_s2_d = href_s1_q;

    phase_d   = href_s1_q & ~phase_q;
    hi_byte_d = (href_s1_q & ~phase_q) ? byte_s1_q : hi_byte_q;
    pix_d     = pix_stb ? {hi_byte_q, byte_s1_q} : pix_q;
    pix_vld_d = pix_stb;

    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_bad_d    = line_bad_q;
    skip_cnt_d    = skip_cnt_q;
    frame_valid_d = frame_valid_q;
    seen_d        = seen_q;
    frame_err_d   = frame_err_q;

    if (pix_stb && (pix_cnt_q != '1)) begin
      pix_cnt_d = pix_cnt_q + 11'd1;
    end

    // phase_q still set at the falling edge means a high byte was left over
    if (href_fall) begin
      pix_cnt_d = '0;
      if (line_cnt_q != '1) begin
        line_cnt_d = line_cnt_q + 10'd1;
      end
      if ((pix_cnt_q != H_PIX_LIM) || phase_q) begin
        line_bad_d = 1'b1;
      end
    end

    // a line ending on this same cycle is judged with the closing frame
    if (frame_start) begin
      frame_err_d = seen_q & (line_bad_d | (line_cnt_d != V_LIN_LIM));
      seen_d      = 1'b1;
      line_bad_d  = 1'b0;
      line_cnt_d  = '0;
      if (skip_cnt_q < SKIP_LIM) begin
        skip_cnt_d = skip_cnt_q + 8'd1;
      end
      if (skip_cnt_q == SKIP_LIM) begin
        frame_valid_d = 1'b1;
      end
    end

    cam_vs_d   = vs_s2_q & frame_valid_q;
    cam_de_d   = href_s2_q & frame_valid_q;
    data_en_d  = pix_vld_q & frame_valid_q;
    cam_data_d = (pix_vld_q & frame_valid_q) ? pix_q : cam_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      href_s1_q     <= 1'b0;
      href_s2_q     <= 1'b0;
      byte_s1_q     <= '0;
      phase_q       <= 1'b0;
      hi_byte_q     <= '0;
      pix_q         <= '0;
      pix_vld_q     <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_bad_q    <= 1'b0;
      skip_cnt_q    <= '0;
      frame_valid_q <= 1'b0;
      seen_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      cam_vs_q      <= 1'b0;
      cam_de_q      <= 1'b0;
      data_en_q     <= 1'b0;
      cam_data_q    <= '0;
    end else begin
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      href_s1_q     <= href_s1_d;
      href_s2_q     <= href_s2_d;
      byte_s1_q     <= byte_s1_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      pix_q         <= pix_d;
      pix_vld_q     <= pix_vld_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_bad_q    <= line_bad_d;
      skip_cnt_q    <= skip_cnt_d;
      frame_valid_q <= frame_valid_d;
      seen_q        <= seen_d;
      frame_err_q   <= frame_err_d;
      cam_vs_q      <= cam_vs_d;
      cam_de_q      <= cam_de_d;
      data_en_q     <= data_en_d;
      cam_data_q    <= cam_data_d;
    end
  end

  assign bus.cam_vs    = cam_vs_q;
  assign bus.cam_de    = cam_de_q;
  assign bus.data_en   = data_en_q;
  assign bus.cam_data  = cam_data_q;
  assign bus.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_capture
// Brief    : Directed bench for cmos_capture with 4x2 frames, skip of 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmos_capture_if bus_if();

  cmos_capture #(
    .FRAME_SKIP (2),
    .H_PIX      (4),
    .V_LINES    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int en_cnt = 0;
  int vs_cnt = 0;
  int de_cnt = 0;
  int de_viol = 0;
  int rate_viol = 0;
  logic prev_en = 1'b0;
  logic [15:0] pix_log[$];
  int en_cyc[$];
  int lo_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, let the posedge pass, observe at the negedge
  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    bus_if.cmos_vsync = vs;
    bus_if.cmos_href  = hr;
    bus_if.cmos_data  = d;
    @(negedge clk);
    cyc_n++;
    if (bus_if.data_en) begin
      en_cnt++;
      pix_log.push_back(bus_if.cam_data);
      en_cyc.push_back(cyc_n);
      if (!bus_if.cam_de) de_viol++;
      if (prev_en) rate_viol++;
    end
    if (bus_if.cam_vs) vs_cnt++;
    if (bus_if.cam_de) de_cnt++;
    prev_en = bus_if.data_en;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fstart();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic send_line(input int n, input logic [79:0] b);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 1) lo_cyc.push_back(cyc_n + 1);
      cyc(1'b0, 1'b1, b[79-8*i -: 8]);
    end
    idle(2);
  endtask

  task automatic good_lines();
    send_line(8, 80'h0102030405060708_0000);
    send_line(8, 80'h1112131415161718_0000);
  endtask

  task automatic clear_log();
    pix_log.delete();
    en_cyc.delete();
    lo_cyc.delete();
  endtask

  logic [15:0] exp3 [8] = '{16'hF81F, 16'h07E0, 16'h1234, 16'h5678,
                            16'h9ABC, 16'hDEF0, 16'h0123, 16'h4567};

  initial begin
    int e0, d0, v0;
    bus_if.cmos_vsync = 1'b0;
    bus_if.cmos_href  = 1'b0;
    bus_if.cmos_data  = 8'h00;
    @(negedge clk);

    // reset with random bus activity
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    check("rst_cam_vs",    32'(bus_if.cam_vs),    0);
    check("rst_cam_de",    32'(bus_if.cam_de),    0);
    check("rst_data_en",   32'(bus_if.data_en),   0);
    check("rst_cam_data",  32'(bus_if.cam_data),  0);
    check("rst_frame_err", 32'(bus_if.frame_err), 0);
    rst = 1'b0;
    idle(3);

    // frame 1 (skipped, short second line), frame 2 (skipped, good)
    fstart();
    check("first_err", 32'(bus_if.frame_err), 0);
    send_line(8, 80'h0102030405060708_0000);
    send_line(6, 80'hAABBCCDDEEFF_00000000);
    fstart();
    check("skip_err", 32'(bus_if.frame_err), 1);
    good_lines();
    check("skip_en", 32'(en_cnt), 0);
    check("skip_de", 32'(de_cnt), 0);
    check("skip_vs", 32'(vs_cnt), 0);

    // frame 3: first passed frame, byte assembly and latency
    clear_log();
    d0 = de_cnt;
    fstart();
    check("f3_err", 32'(bus_if.frame_err), 0);
    check("f3_vs_seen", 32'(vs_cnt != 0), 1);
    send_line(8, 80'hF81F07E012345678_0000);
    send_line(8, 80'h9ABCDEF001234567_0000);
    check("f3_count", 32'(pix_log.size()), 8);
    for (int i = 0; i < 8 && i < pix_log.size(); i++) begin
      check($sformatf("f3_pix%0d", i), 32'(pix_log[i]), 32'(exp3[i]));
      check($sformatf("f3_lat%0d", i), 32'(en_cyc[i]), 32'(lo_cyc[i] + 2));
    end
    check("f3_de_cycles", 32'(de_cnt - d0), 16);

    // frame 4: good
    e0 = en_cnt;
    fstart();
    good_lines();
    check("f4_count", 32'(en_cnt - e0), 8);

    // frame 5: second line only 3 pixels
    fstart();
    check("f5_err", 32'(bus_if.frame_err), 0);
    e0 = en_cnt;
    send_line(8, 80'h2122232425262728_0000);
    send_line(6, 80'h313233343536_00000000);
    check("f5_count", 32'(en_cnt - e0), 7);
    check("f5_err_hold", 32'(bus_if.frame_err), 0);

    // frame 6: good; reports the short line of frame 5
    fstart();
    check("geom_err_set", 32'(bus_if.frame_err), 1);
    good_lines();
    check("geom_err_hold", 32'(bus_if.frame_err), 1);

    // frame 7: odd byte count on first line
    fstart();
    check("geom_err_clr", 32'(bus_if.frame_err), 0);
    clear_log();
    send_line(9, 80'h112233445566778899_00);
    send_line(8, 80'hA1A2A3A4A5A6A7A8_0000);
    check("odd_count", 32'(pix_log.size()), 8);
    if (pix_log.size() >= 5) begin
      check("odd_last_pix",  32'(pix_log[3]), 32'h7788);
      check("odd_next_line", 32'(pix_log[4]), 32'hA1A2);
    end

    // frame 8: flags odd byte, then reset mid-line
    fstart();
    check("odd_err", 32'(bus_if.frame_err), 1);
    cyc(1'b0, 1'b1, 8'h41);
    cyc(1'b0, 1'b1, 8'h42);
    cyc(1'b0, 1'b1, 8'h43);
    cyc(1'b0, 1'b1, 8'h44);
    check("pre_rst_de", 32'(bus_if.cam_de), 1);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h45);
    rst = 1'b0;
    check("mrst_cam_vs",    32'(bus_if.cam_vs),    0);
    check("mrst_cam_de",    32'(bus_if.cam_de),    0);
    check("mrst_data_en",   32'(bus_if.data_en),   0);
    check("mrst_cam_data",  32'(bus_if.cam_data),  0);
    check("mrst_frame_err", 32'(bus_if.frame_err), 0);
    cyc(1'b0, 1'b1, 8'h46);
    cyc(1'b0, 1'b1, 8'h47);
    cyc(1'b0, 1'b1, 8'h48);
    idle(2);

    // two skipped frames after reset, then output resumes
    e0 = en_cnt; d0 = de_cnt; v0 = vs_cnt;
    fstart();
    check("mrst_first_err", 32'(bus_if.frame_err), 0);
    good_lines();
    fstart();
    good_lines();
    check("mrst_skip_en", 32'(en_cnt - e0), 0);
    check("mrst_skip_de", 32'(de_cnt - d0), 0);
    check("mrst_skip_vs", 32'(vs_cnt - v0), 0);
    e0 = en_cnt;
    fstart();
    good_lines();
    check("mrst_resume", 32'(en_cnt - e0), 8);
    idle(2);

    check("de_gating", 32'(de_viol), 0);
    check("en_rate", 32'(rate_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
